// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero and a per-register busy scoreboard.
// Optional write-first read forwarding is compiled in with `define REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NRD*$clog2(NREGS)-1:0]     raddr,
    output logic [NRD*XLEN-1:0]              rdata,
    output logic [NRD-1:0]                   rbusy,
    input  logic [NWR-1:0]                   wen,
    input  logic [NWR*$clog2(NREGS)-1:0]     waddr,
    input  logic [NWR*XLEN-1:0]              wdata,
    input  logic                             alloc_en,
    input  logic [$clog2(NREGS)-1:0]         alloc_addr,
    output logic [$clog2(NREGS):0]           busy_cnt
);

    localparam int AW = $clog2(NREGS);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] rs_reg  [NREGS];
    logic [XLEN-1:0] rs_next [NREGS];
    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;
    logic [CW-1:0]    busy_cnt_reg;
    logic [CW-1:0]    busy_cnt_next;

    // Ascending port order lets the highest-index write win; alloc is applied last so set beats clear.
    always_comb begin
        rs_next   = rs_reg;
        busy_next = busy_reg;
        for (int j = 0; j < NWR; j++) begin
            if (wen[j] && (waddr[j*AW +: AW] != '0)) begin
                rs_next[waddr[j*AW +: AW]]   = wdata[j*XLEN +: XLEN];
                busy_next[waddr[j*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en && (alloc_addr != '0)) begin
            busy_next[alloc_addr] = 1'b1;
        end
    end

    always_comb begin
        busy_cnt_next = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy_cnt_next = busy_cnt_next + CW'(busy_next[r]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                rs_reg[r] <= '0;
            end
            busy_reg     <= '0;
            busy_cnt_reg <= '0;
        end else begin
            rs_reg       <= rs_next;
            busy_reg     <= busy_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign busy_cnt = busy_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] ra;
            assign ra = raddr[gi*AW +: AW];
`ifdef REGFILE_BYPASS_EN
            logic [XLEN-1:0] data_sel;
            logic            busy_sel;
            // Forwarded write data would otherwise leak through while the file is held in reset.
            always_comb begin
                data_sel = rs_reg[ra];
                busy_sel = busy_reg[ra];
                for (int j = 0; j < NWR; j++) begin
                    if (wen[j] && (waddr[j*AW +: AW] == ra) && (ra != '0)) begin
                        data_sel = wdata[j*XLEN +: XLEN];
                        busy_sel = alloc_en && (alloc_addr == ra);
                    end
                end
                if (rst) begin
                    data_sel = '0;
                    busy_sel = 1'b0;
                end
            end
            assign rdata[gi*XLEN +: XLEN] = data_sel;
            assign rbusy[gi]              = busy_sel;
`else
            assign rdata[gi*XLEN +: XLEN] = rs_reg[ra];
            assign rbusy[gi]              = busy_reg[ra];
`endif
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp (2 read, 2 write ports) against an array-based model.
// Define REGFILE_BYPASS_EN for both files to exercise write-first reads.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      wen;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic [AW:0]         busy_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [XLEN-1:0] model_rs   [NREGS];
    bit              model_busy [NREGS];

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen(wen), .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic void model_clear();
        for (int r = 0; r < NREGS; r++) begin
            model_rs[r]   = '0;
            model_busy[r] = 0;
        end
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int r = 0; r < NREGS; r++) c += model_busy[r] ? 1 : 0;
        return c;
    endfunction

    // Value a read of register a should return right now, before the next edge.
    function automatic logic [31:0] exp_rdata(input logic [AW-1:0] a);
        logic [31:0] v;
        if (a == 0 || rst) return 32'h0;
        v = model_rs[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++)
            if (wen[j] && waddr[j*AW +: AW] == a) v = wdata[j*XLEN +: XLEN];
`endif
        return v;
    endfunction

    function automatic logic exp_rbusy(input logic [AW-1:0] a);
        if (a == 0 || rst) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++)
            if (wen[j] && waddr[j*AW +: AW] == a) return alloc_en && alloc_addr == a;
`endif
        return model_busy[a];
    endfunction

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic ae, input logic [4:0] aa,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        wen        = we;
        waddr      = {wa1, wa0};
        wdata      = {wd1, wd0};
        alloc_en   = ae;
        alloc_addr = aa;
        raddr      = {ra1, ra0};
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rdata0"}, rdata[31:0],  exp_rdata(raddr[4:0]));
        check({tag, ".rdata1"}, rdata[63:32], exp_rdata(raddr[9:5]));
        check({tag, ".rbusy0"}, 32'(rbusy[0]), 32'(exp_rbusy(raddr[4:0])));
        check({tag, ".rbusy1"}, 32'(rbusy[1]), 32'(exp_rbusy(raddr[9:5])));
        check({tag, ".busy_cnt"}, 32'(busy_cnt), 32'(model_count()));
    endtask

    // One clock edge: the model consumes the inputs held across it.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && waddr[j*AW +: AW] != 0) begin
                    model_rs[waddr[j*AW +: AW]]   = wdata[j*XLEN +: XLEN];
                    model_busy[waddr[j*AW +: AW]] = 0;
                end
            end
            if (alloc_en && alloc_addr != 0) model_busy[alloc_addr] = 1;
        end
        $display("cyc %0d rst=%0b wen=%b wa=%0d/%0d alloc=%0b@%0d ra=%0d/%0d cnt=%0d",
                 cyc, rst, wen, waddr[4:0], waddr[9:5], alloc_en, alloc_addr,
                 raddr[4:0], raddr[9:5], busy_cnt);
        cyc++;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        model_clear();
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset.busy_cnt", 32'(busy_cnt), 32'd0);
        check("reset.rdata0", rdata[31:0], 32'h0);

        // Basic write and x0 protection
        drive(2'b01, 15, 32'hABCDEFAA, 0, 0, 0, 0, 15, 0);
        tick();
        drive(2'b01, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 15, 0);
        tick();
        drive(2'b00, 0, 0, 0, 0, 1, 9, 15, 0);
        check("wr.r15", rdata[31:0], 32'hABCDEFAA);
        check("wr.x0", rdata[63:32], 32'h0);
        tick();
        drive(2'b00, 0, 0, 0, 0, 0, 0, 15, 9);
        check("pre_rst.rbusy9", 32'(rbusy[1]), 32'd1);
        check("pre_rst.busy_cnt", 32'(busy_cnt), 32'd1);

        // Asynchronous reset takes effect without an edge
        rst = 1'b1;
        model_clear();
        #1;
        check("async_rst.r15", rdata[31:0], 32'h0);
        check("async_rst.rbusy9", 32'(rbusy[1]), 32'd0);
        check("async_rst.busy_cnt", 32'(busy_cnt), 32'd0);
        tick();
        rst = 1'b0;

        // Write conflict: port 1 wins
        drive(2'b11, 7, 32'h11111111, 7, 32'h22222222, 0, 0, 7, 0);
        tick();
        drive(2'b00, 0, 0, 0, 0, 0, 0, 7, 0);
        check("conflict.r7", rdata[31:0], 32'h22222222);

        // Scoreboard sequence
        drive(2'b00, 0, 0, 0, 0, 1, 5, 5, 0);
        tick();
        drive(2'b00, 0, 0, 0, 0, 0, 0, 5, 0);
        check("sb.alloc.rbusy", 32'(rbusy[0]), 32'd1);
        check("sb.alloc.cnt", 32'(busy_cnt), 32'd1);
        drive(2'b01, 5, 32'h55AA55AA, 0, 0, 1, 5, 0, 5);
        tick();
        drive(2'b00, 0, 0, 0, 0, 0, 0, 5, 0);
        check("sb.both.rbusy", 32'(rbusy[0]), 32'd1);
        check("sb.both.data", rdata[31:0], 32'h55AA55AA);
        check("sb.both.cnt", 32'(busy_cnt), 32'd1);
        drive(2'b10, 0, 0, 5, 32'h01020304, 0, 0, 0, 5);
        tick();
        drive(2'b00, 0, 0, 0, 0, 0, 0, 5, 0);
        check("sb.clr.rbusy", 32'(rbusy[0]), 32'd0);
        check("sb.clr.cnt", 32'(busy_cnt), 32'd0);

        // Same-cycle write and read of r3
        drive(2'b01, 3, 32'h12345678, 0, 0, 0, 0, 0, 0);
        tick();
        drive(2'b01, 3, 32'hDEADBEEF, 0, 0, 0, 0, 3, 0);
`ifdef REGFILE_BYPASS_EN
        check("bypass.before", rdata[31:0], 32'hDEADBEEF);
`else
        check("bypass.before", rdata[31:0], 32'h12345678);
`endif
        tick();
        drive(2'b00, 0, 0, 0, 0, 0, 0, 3, 0);
        check("bypass.after", rdata[31:0], 32'hDEADBEEF);

        // Random regression with occasional reset pulses
        for (int n = 0; n < 1000; n++) begin
            logic [4:0] a0, a1, aa, r0, r1;
            a0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            aa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            r0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 39) == 0);
            if (rst) model_clear();
            drive(2'($urandom), a0, $urandom, a1, $urandom,
                  1'($urandom_range(0, 2) == 0), aa, r0, r1);
            check_all("rand");
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
